// File: rtl/bo_seq_pkg.sv
// Shared encodings for the BO sequencer: FSM states, program codes, ULA
// operation and datapath mux selects.
package bo_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MUL,
        S_ADDB,
        S_SUBC,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_AX     = 2'b00;
    localparam logic [1:0] OP_AXB    = 2'b01;
    localparam logic [1:0] OP_AXBC   = 2'b10;
    localparam logic [1:0] OP_ABC    = 2'b11;

    localparam logic       ULA_ADD   = 1'b0;
    localparam logic       ULA_SUB   = 1'b1;

    localparam logic [1:0] M0_ZERO   = 2'b00;
    localparam logic [1:0] M0_A      = 2'b01;
    localparam logic [1:0] M0_B      = 2'b10;
    localparam logic [1:0] M0_C      = 2'b11;

    localparam logic [1:0] M1_M0     = 2'b00;
    localparam logic [1:0] M1_RX     = 2'b01;
    localparam logic [1:0] M1_RS     = 2'b10;
    localparam logic [1:0] M1_RH     = 2'b11;

    localparam logic [1:0] M2_RX     = 2'b00;
    localparam logic [1:0] M2_M0     = 2'b01;
    localparam logic [1:0] M2_RS     = 2'b10;
    localparam logic [1:0] M2_RH     = 2'b11;

    // Every program except plain A*X finishes with the +B step.
    function automatic logic op_has_addb(input logic [1:0] op);
        return op != OP_AX;
    endfunction

    function automatic logic op_has_subc(input logic [1:0] op);
        return (op == OP_AXBC) || (op == OP_ABC);
    endfunction

endpackage

// File: rtl/bo_loop_counter.sv
// Down-counter for the repeated-addition loop; last flags the final pass.
module bo_loop_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bo_sequencer.sv
// Control FSM for the BO datapath: runs one of four fixed programs per start
// pulse, with multiplication as repeated addition of A into RS.
module bo_sequencer
    import bo_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] X,
    input  logic             Overflow,
    output logic             LX,
    output logic             LS,
    output logic             LH,
    output logic             SEL_ULA,
    output logic [1:0]       M0,
    output logic [1:0]       M1,
    output logic [1:0]       M2,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_last;

    // A+B-C reuses the MUL step once to bring A into RS.
    assign cnt_load_val = (op_q == OP_ABC) ? CNT_W'(1) : X;

    bo_loop_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == S_CLR),
        .load_val (cnt_load_val),
        .dec      (state_q == S_MUL),
        .last     (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ovf_d   = ovf_q;
        LX      = 1'b0;
        LS      = 1'b0;
        LH      = 1'b0;
        SEL_ULA = ULA_ADD;
        M0      = M0_ZERO;
        M1      = M1_M0;
        M2      = M2_RX;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    ovf_d   = 1'b0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                busy = 1'b1;
                LX   = 1'b1;
                LS   = 1'b1;
                M2   = M2_M0;
                if (cnt_load_val != '0) begin
                    state_d = S_MUL;
                end else if (op_has_addb(op_q)) begin
                    state_d = S_ADDB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_MUL: begin
                busy  = 1'b1;
                LS    = 1'b1;
                M0    = M0_A;
                M2    = M2_RS;
                ovf_d = ovf_q | Overflow;
                if (cnt_last) begin
                    state_d = op_has_addb(op_q) ? S_ADDB : S_DONE;
                end
            end
            S_ADDB: begin
                busy    = 1'b1;
                LS      = 1'b1;
                M0      = M0_B;
                M2      = M2_RS;
                ovf_d   = ovf_q | Overflow;
                state_d = op_has_subc(op_q) ? S_SUBC : S_DONE;
            end
            S_SUBC: begin
                busy    = 1'b1;
                LS      = 1'b1;
                M0      = M0_C;
                M2      = M2_RS;
                SEL_ULA = ULA_SUB;
                ovf_d   = ovf_q | Overflow;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AX;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_bo_sequencer.sv
// Bench for bo_sequencer: a behavioural BO datapath closes the loop, and each
// program is checked for result, completion cycle and sticky overflow.
module tb_bo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  X = 8'h00;
    logic        Overflow;
    logic        LX, LS, LH, SEL_ULA, busy, done, ovf;
    logic [1:0]  M0, M1, M2;
    logic [15:0] A = 16'h0, B = 16'h0, C = 16'h0;

    // BO datapath model
    logic [15:0] rx, rs, rh;
    logic [15:0] m0_out, m1_out, m2_out;
    logic [16:0] ula;

    int n_pass = 0;
    int n_total = 0;

    bo_sequencer #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .X        (X),
        .Overflow (Overflow),
        .LX       (LX),
        .LS       (LS),
        .LH       (LH),
        .SEL_ULA  (SEL_ULA),
        .M0       (M0),
        .M1       (M1),
        .M2       (M2),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        m0_out = 16'h0;
        m1_out = 16'h0;
        m2_out = 16'h0;
        case (M0)
            2'b00: m0_out = 16'h0;
            2'b01: m0_out = A;
            2'b10: m0_out = B;
            default: m0_out = C;
        endcase
        case (M1)
            2'b00: m1_out = m0_out;
            2'b01: m1_out = rx;
            2'b10: m1_out = rs;
            default: m1_out = rh;
        endcase
        case (M2)
            2'b00: m2_out = rx;
            2'b01: m2_out = m0_out;
            2'b10: m2_out = rs;
            default: m2_out = rh;
        endcase
        ula = SEL_ULA ? ({1'b0, m2_out} - {1'b0, m1_out})
                      : ({1'b0, m2_out} + {1'b0, m1_out});
        Overflow = ula[16];
    end

    always @(posedge clk) begin
        if (LX) rx <= {8'h00, X};
        if (LS) rs <= ula[15:0];
        if (LH) rh <= ula[15:0];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Program semantics as plain arithmetic on unsigned 16-bit values;
    // any carry out of an add or borrow from a subtract sets overflow.
    function automatic void ref_model(input int o, input int x, input int a, input int b,
                                      input int c, output int res, output int cyc,
                                      output int ov);
        int s;
        int nmul;
        s    = 0;
        ov   = 0;
        nmul = (o == 3) ? 1 : x;
        for (int i = 0; i < nmul; i++) begin
            s = s + a;
            if (s > 65535) begin ov = 1; s = s - 65536; end
        end
        if (o != 0) begin
            s = s + b;
            if (s > 65535) begin ov = 1; s = s - 65536; end
        end
        if (o >= 2) begin
            if (c > s) begin ov = 1; s = s + 65536 - c; end
            else s = s - c;
        end
        res = s;
        cyc = 2 + nmul + ((o != 0) ? 1 : 0) + ((o >= 2) ? 1 : 0);
    endfunction

    task automatic run_op(input string nm, input int o, input int x, input int a,
                          input int b, input int c, input int exp_res,
                          input int exp_cyc, input int exp_ov);
        int cyc, busy_n, lx_n, lh_n, got, lx1;
        @(negedge clk);
        op = 2'(o); X = 8'(x); A = 16'(a); B = 16'(b); C = 16'(c);
        start = 1'b1;
        cyc = 0; busy_n = 0; lx_n = 0; lh_n = 0; got = 0; lx1 = 0;
        while (got == 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            busy_n += int'(busy);
            lx_n   += int'(LX);
            lh_n   += int'(LH);
            if (cyc == 1) lx1 = int'(LX);
            if (done) got = 1;
        end
        $display("op=%0d X=%0d A=%0d B=%0d C=%0d -> res=%0d cyc=%0d ovf=%0d",
                 o, x, a, b, c, rs, cyc, ovf);
        check({nm, "_done_seen"}, 32'(got), 32'd1);
        check({nm, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({nm, "_result"}, {16'h0, rs}, 32'(exp_res));
        check({nm, "_ovf"}, {31'h0, ovf}, 32'(exp_ov));
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_cyc - 1));
        check({nm, "_clr_at_1"}, 32'(lx1 * 16 + lx_n), 32'h11);
        check({nm, "_lh_never"}, 32'(lh_n), 32'd0);
        @(negedge clk);
        check({nm, "_idle_hold"}, {29'h0, busy, done, ovf}, 32'(exp_ov));
    endtask

    typedef struct {
        int op, x, a, b, c;
        int res, cyc, ov;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int r_res, r_cyc, r_ov;
        int cyc, ndone, first_done, lx7, busy6, second_done;

        vecs[0] = '{2, 3,   5,      7,  2,  20,     7,   0};
        vecs[1] = '{0, 0,   1234,   0,  0,  0,      2,   0};
        vecs[2] = '{0, 255, 1,      0,  0,  255,    257, 0};
        vecs[3] = '{3, 0,   100,    50, 30, 120,    5,   0};
        vecs[4] = '{0, 2,   32768,  0,  0,  0,      4,   1};
        vecs[5] = '{3, 0,   1,      1,  1,  1,      5,   0};
        vecs[6] = '{1, 1,   3,      4,  0,  7,      4,   0};
        vecs[7] = '{2, 0,   0,      5,  9,  65532,  4,   1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {20'h0, LX, LS, LH, SEL_ULA, M0, M1, M2, busy, done, ovf}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].a, vecs[i].b,
                   vecs[i].c, vecs[i].res, vecs[i].cyc, vecs[i].ov);
        end

        // start pulsed mid-MUL must be ignored
        @(negedge clk);
        op = 2'b00; X = 8'd10; A = 16'd3; start = 1'b1;
        cyc = 0; ndone = 0; first_done = -1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
            end
            start = (cyc == 4);
        end
        $display("start-in-MUL: dones=%0d first=%0d res=%0d", ndone, first_done, rs);
        check("ignore_start_ndone", 32'(ndone), 32'd1);
        check("ignore_start_cycle", 32'(first_done), 32'd12);
        check("ignore_start_result", {16'h0, rs}, 32'd30);

        // start held through DONE: re-accepted in the following IDLE cycle
        @(negedge clk);
        op = 2'b11; A = 16'd1; B = 16'd1; C = 16'd1; start = 1'b1;
        cyc = 0; ndone = 0; first_done = -1; second_done = -1; lx7 = 0; busy6 = 1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = cyc;
                else second_done = cyc;
            end
            if (cyc == 6) busy6 = int'(busy);
            if (cyc == 7) begin lx7 = int'(LX); start = 1'b0; end
        end
        $display("start-held: dones=%0d at %0d,%0d res=%0d", ndone, first_done, second_done, rs);
        check("held_start_ndone", 32'(ndone), 32'd2);
        check("held_start_first", 32'(first_done), 32'd5);
        check("held_start_second", 32'(second_done), 32'd11);
        check("held_start_idle_gap", 32'(busy6), 32'd0);
        check("held_start_clr", 32'(lx7), 32'd1);

        // async reset mid-MUL
        @(negedge clk);
        op = 2'b00; X = 8'd50; A = 16'd1; start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_in_mul", {30'h0, LS, busy}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-MUL: LS=%0b LX=%0b busy=%0b", LS, LX, busy);
        check("async_reset_strobes", {20'h0, LX, LS, LH, SEL_ULA, M0, M1, M2, busy, done, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 1, 1, 3, 4, 0, 7, 4, 0);

        // randomized programs against the arithmetic reference
        for (int i = 0; i < 24; i++) begin
            int o, x, a, b, c;
            o = int'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            c = int'($urandom_range(0, 65535));
            if (i % 3 == 0) begin
                a = a % 300; b = b % 300;
            end
            ref_model(o, x, a, b, c, r_res, r_cyc, r_ov);
            run_op($sformatf("rand%0d", i), o, x, a, b, c, r_res, r_cyc, r_ov);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bo_sequencer.md
Name: bo_sequencer

Overview:
- Control block (FSM) that drives the BO datapath: loads RX, steers mux selects M0/M1/M2, selects ULA operation, and strobes the RS/RH load enables.
- It evaluates one of four fixed programs per start pulse. Multiplication is done by repeated addition, with the loop counter held inside this block.
- It sits beside BO. Its outputs connect 1:1 to BO control inputs, and BO Overflow feeds back into it.

Parameters:
- CNT_W, 8, width of X and of the internal loop counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  program: 00 S=A*X; 01 S=A*X+B; 10 S=A*X+B-C; 11 S=A+B-C.
- X  in  CNT_W  multiplier; same bus that feeds BO.X.
- Overflow  in  1  BO ULA overflow (combinational).
- LX, LS, LH  out  1  BO register load enables.
- SEL_ULA  out  1  0 = add (M2+M1), 1 = subtract (M2-M1).
- M0  out  2  mux0 select: 00 zero, 01 A, 10 B, 11 C.
- M1  out  2  mux1 select: 00 M0_OUT, 01 RX, 10 RS, 11 RH.
- M2  out  2  mux2 select: 00 RX, 01 M0_OUT, 10 RS, 11 RH.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse; Resultado is valid while it is high.
- ovf  out  1  sticky overflow for the current/last operation.

Behaviour:
- States: IDLE, CLR, MUL, ADDB, SUBC, DONE. Outputs are Moore-decoded from the state register.
- Reset (async): state=IDLE, cnt=0, op_r=0, ovf=0. This forces LX=LS=LH=0, SEL_ULA=0, M0=M1=M2=00, busy=0, done=0. BO registers are not reset.
- IDLE:
  - On start=1, latch op into op_r, clear ovf, go to CLR.
  - start in any other state is ignored and not queued.
- CLR:
  - LX=1, M0=00, M1=00, M2=01, SEL_ULA=0, LS=1. This gives RS=0 and RX=X.
  - cnt := (op_r==11) ? 1 : X.
  - Next: MUL if the loaded count is nonzero; otherwise ADDB (op 01/10) or DONE (op 00).
- MUL:
  - M0=01, M1=00, M2=10, SEL_ULA=0, LS=1, i.e. RS := RS+A. cnt := cnt-1.
  - Stay in MUL while cnt>1; then ADDB (op 01/10/11) or DONE (op 00).
- ADDB: M0=10, M1=00, M2=10, SEL_ULA=0, LS=1 (RS := RS+B). Next: SUBC for op 10/11, else DONE.
- SUBC: M0=11, M1=00, M2=10, SEL_ULA=1, LS=1 (RS := RS-C). Next: DONE.
- DONE: done=1, busy=0, all loads 0. Next: IDLE.
- Unused outputs: LH is held 0 in all states (reserved for future programs).
- Overflow handling:
  - On every edge where LS=1 and the state is MUL/ADDB/SUBC: ovf |= Overflow.
  - Overflow is not sampled in CLR.
  - ovf holds its value through DONE and IDLE until the next accepted start.
- Cycle counts, with the start-accept edge as cycle 0: CLR=cycle 1; DONE at 2 + N_MUL + N_ADDB + N_SUBC.
- Input stability: X, A, B, C, op must be stable from the start cycle through DONE.
- Reset mid-operation: immediate return to IDLE with all strobes low. The partial RS value is not meaningful.
- X = 2^CNT_W-1 must run the full 255 MUL iterations; there is no counter wrap.

Decomposition:
- Package bo_seq_pkg holds:
  - state enum
  - OP_* codes (2 bits)
  - ULA_ADD=0, ULA_SUB=1
  - mux select constants: M0_ZERO/A/B/C, M1_M0/RX/RS/RH, M2_RX/M0/RS/RH
- Optional sub-module: bo_loop_counter, a CNT_W down-counter with load, dec, and last (cnt==1) outputs.
- Top-level test wrapper instantiates BO + bo_sequencer.

Test Plan:
- op=10, X=3, A=5, B=7, C=2 -> CLR@1, MUL@2-4, ADDB@5, SUBC@6, done@7, Resultado=20, ovf=0.
- op=00, X=0, A=1234 -> CLR@1, done@2, Resultado=0, no MUL-state cycle; X=255, A=1 -> done@257, Resultado=255.
- op=11, A=100, B=50, C=30 (X ignored) -> done@5, Resultado=120.
- op=00, X=2, A=16'h8000 -> Resultado=16'h0000, ovf=1 at done. A following op=11 with A=1, B=1, C=1 -> ovf cleared at accept, Resultado=1, ovf=0.
- start pulsed during MUL -> ignored, single done. start held high across DONE -> new op accepted in the following IDLE cycle, CLR one cycle later.
- rst_n low mid-MUL -> same-cycle (async) LS=LX=0, busy=0, state IDLE. After release, start with op=01, X=1, A=3, B=4 -> Resultado=7.
